// File: rtl/mips_run_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_pkg
//  Purpose  : Shared types and default constants for the MIPS_SCP run
//             controller (state encoding, halt instruction, reset hold).
//  Revision : 1.0 - initial release
// ============================================================================
package mips_run_pkg;

    // Controller phases, in the order a normal program run visits them.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        RST  = 3'd2,
        RUN  = 3'd3,
        DONE = 3'd4
    } run_state_t;

    // Instruction word that ends a run early.
    localparam logic [31:0] c_HALT_WORD_DEF    = 32'hFFFF_FFFF;

    // Cycles the core is held in reset between load and run.
    localparam int          c_RESET_CYCLES_DEF = 1;

endpackage
`default_nettype wire

// File: rtl/mips_run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_ctrl_if
//  Purpose  : Host/loader/core-facing bundle of the run controller.
//             slave  : controller side (mips_run_ctrl)
//             master : host, loader and MIPS_SCP side
//  Signals  : start, ld_count, run_cycles     - run request
//             ld_valid, ld_data, ld_ready     - program stream
//             imem_we, imem_addr, imem_wdata  - imem write port
//             cpu_instr, cpu_reset            - core fetch / reset
//             busy, done, halted, cycle_count - status
//  Revision : 1.0 - initial release
// ============================================================================
interface mips_run_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [ADDR_W:0]   ld_count;
    logic [CNT_W-1:0]  run_cycles;
    logic              ld_valid;
    logic [31:0]       ld_data;
    logic              ld_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [31:0]       cpu_instr;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              halted;
    logic [CNT_W-1:0]  cycle_count;

    modport slave (
        input  start, ld_count, run_cycles, ld_valid, ld_data, cpu_instr,
        output ld_ready, imem_we, imem_addr, imem_wdata, cpu_reset,
               busy, done, halted, cycle_count
    );

    modport master (
        output start, ld_count, run_cycles, ld_valid, ld_data, cpu_instr,
        input  ld_ready, imem_we, imem_addr, imem_wdata, cpu_reset,
               busy, done, halted, cycle_count
    );

endinterface
`default_nettype wire

// File: rtl/mips_run_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_counter
//  Purpose  : Up-counter with synchronous clear and a terminal-count flag
//             that looks one step ahead: o_last is high when the next
//             increment would make the count equal i_limit.
//  Ports    : clk, rst (async, active-high)
//             i_clr   - clear to zero (wins over i_en)
//             i_en    - increment
//             i_limit - terminal count
//             o_count - current count
//             o_last  - count + 1 == i_limit
//  Revision : 1.0 - initial release
// ============================================================================
module mips_run_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_clr,
    input  wire logic         i_en,
    input  wire logic [W-1:0] i_limit,
    output logic      [W-1:0] o_count,
    output logic              o_last
);

    logic [W-1:0] r_count;
    logic [W-1:0] w_count_inc;

    assign w_count_inc = r_count + W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_count_inc;
        end
    end

    assign o_count = r_count;
    assign o_last  = (w_count_inc == i_limit);

endmodule
`default_nettype wire

// File: rtl/mips_run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_run_ctrl
//  Purpose  : Run controller for MIPS_SCP. Streams a program into imem,
//             holds the core in reset, releases it for a programmed number
//             of cycles (or until a halt word is fetched), then parks it.
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous active-high controller reset
//             bus   - mips_run_ctrl_if.slave (run request, program stream,
//                     imem write port, core reset/fetch, status)
//  Revision : 1.0 - initial release
// ============================================================================
module mips_run_ctrl
    import mips_run_pkg::*;
#(
    parameter int          ADDR_W       = 8,
    parameter int          RESET_CYCLES = c_RESET_CYCLES_DEF,
    parameter int          CNT_W        = 16,
    parameter logic [31:0] HALT_WORD    = c_HALT_WORD_DEF
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mips_run_ctrl_if.slave bus
);

    localparam int              c_RST_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [ADDR_W:0] c_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    run_state_t         r_state;
    run_state_t         w_state_nxt;
    logic [ADDR_W:0]    r_ld_count;
    logic [CNT_W-1:0]   r_run_cycles;
    logic [c_RST_W-1:0] r_rst_cnt;
    logic               r_cpu_reset;
    logic               r_busy;
    logic               r_done;
    logic               r_halted;

    logic               w_start_ok;
    logic [ADDR_W:0]    w_ld_clamped;
    logic               w_xfer;
    logic               w_halt;
    logic               w_run_en;
    logic               w_rst_last;
    logic [ADDR_W:0]    w_ld_addr;
    logic               w_ld_last;
    logic [CNT_W-1:0]   w_cycles;
    logic               w_run_last;

    assign w_start_ok   = bus.start && ((r_state == IDLE) || (r_state == DONE));
    // Larger requests than the memory holds are trimmed so the address never wraps.
    assign w_ld_clamped = (bus.ld_count > c_DEPTH) ? c_DEPTH : bus.ld_count;
    assign w_xfer       = (r_state == LOAD) && bus.ld_valid;
    assign w_halt       = (r_state == RUN) && (bus.cpu_instr == HALT_WORD);
    // The halting cycle itself is not counted.
    assign w_run_en     = (r_state == RUN) && !w_halt;
    assign w_rst_last   = (r_rst_cnt == c_RST_W'(RESET_CYCLES - 1));

    mips_run_counter #(
        .W (ADDR_W + 1)
    ) u_load_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_start_ok),
        .i_en    (w_xfer),
        .i_limit (r_ld_count),
        .o_count (w_ld_addr),
        .o_last  (w_ld_last)
    );

    mips_run_counter #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_clr   (w_start_ok),
        .i_en    (w_run_en),
        .i_limit (r_run_cycles),
        .o_count (w_cycles),
        .o_last  (w_run_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (bus.start) begin
                    w_state_nxt = (w_ld_clamped == '0) ? RST : LOAD;
                end
            end
            LOAD: begin
                if (w_xfer && w_ld_last) begin
                    w_state_nxt = RST;
                end
            end
            RST: begin
                if (w_rst_last) begin
                    w_state_nxt = (r_run_cycles == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_halt || w_run_last) begin
                    w_state_nxt = DONE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State plus status flops; status is decoded from the next state so it
    // lines up with the state register instead of lagging it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_ld_count   <= '0;
            r_run_cycles <= '0;
            r_rst_cnt    <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cpu_reset <= (w_state_nxt != RUN);
            r_busy      <= (w_state_nxt == LOAD) || (w_state_nxt == RST) || (w_state_nxt == RUN);
            r_done      <= (w_state_nxt == DONE);

            if (w_start_ok) begin
                r_ld_count   <= w_ld_clamped;
                r_run_cycles <= bus.run_cycles;
                r_halted     <= 1'b0;
            end else if (w_halt) begin
                r_halted <= 1'b1;
            end

            // Reset-hold counter idles at zero outside RST.
            if ((r_state == RST) && !w_rst_last) begin
                r_rst_cnt <= r_rst_cnt + c_RST_W'(1);
            end else begin
                r_rst_cnt <= '0;
            end
        end
    end

    assign bus.ld_ready    = (r_state == LOAD);
    // Address MSB set means imem is full; blocks any write past the top word.
    assign bus.imem_we     = w_xfer && !w_ld_addr[ADDR_W];
    assign bus.imem_wdata  = (r_state == LOAD) ? bus.ld_data : '0;
    assign bus.imem_addr   = w_ld_addr[ADDR_W-1:0];
    assign bus.cpu_reset   = r_cpu_reset;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.halted      = r_halted;
    assign bus.cycle_count = w_cycles;

endmodule
`default_nettype wire
